// File: rtl/cmps_seq_pkg.sv
// Shared definitions for the CMPS string-compare sequencer:
// state encoding, REP prefix codes, flag bit positions and operand sizes.
package cmps_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    RD_SRC = 3'd2,
    RD_DST = 3'd3,
    CMP    = 3'd4,
    FIN    = 3'd5
  } state_t;

  // rep_mode encodings; 2'b11 behaves like REP_NONE
  localparam logic [1:0] REP_NONE = 2'b00;
  localparam logic [1:0] REPE     = 2'b01;
  localparam logic [1:0] REPNE    = 2'b10;

  // bit positions inside the {OF,SF,ZF,AF,PF,CF} flag vector
  localparam int FLAG_CF   = 0;
  localparam int FLAG_PF   = 1;
  localparam int FLAG_AF   = 2;
  localparam int FLAG_ZF   = 3;
  localparam int FLAG_SF   = 4;
  localparam int FLAG_OF   = 5;
  localparam int NUM_FLAGS = 6;

  // op_size encodings; 2'd3 behaves like SZ_DWORD
  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_WORD  = 2'd1;
  localparam logic [1:0] SZ_DWORD = 2'd2;

  function automatic logic is_rep(input logic [1:0] mode);
    return (mode == REPE) || (mode == REPNE);
  endfunction

endpackage

// File: rtl/cmps_ptr_step.sv
// Pointer step for ESI/EDI: +/-1, +/-2 or +/-4 depending on operand size
// and the direction flag. Result is an AW-bit two's-complement delta.
module cmps_ptr_step
  import cmps_seq_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [1:0]    op_size,
  input  logic          df,
  output logic [AW-1:0] delta
);

  logic [AW-1:0] mag;

  // size selects the magnitude, DF selects the sign
  always_comb begin
    mag   = AW'(4);
    delta = '0;
    case (op_size)
      SZ_BYTE: mag = AW'(1);
      SZ_WORD: mag = AW'(2);
      default: mag = AW'(4);
    endcase
    delta = df ? (~mag + AW'(1)) : mag;
  end

endmodule

// File: rtl/cmps_seq.sv
// CMPS / REPE CMPS / REPNE CMPS execute-stage sequencer.
// Reads [ESI] then [EDI], hands both to the ALU, consumes the flags and
// steps ESI/EDI/ECX once per iteration while stalling the pipeline.
// Optional feature macro: CMPS_SEQ_INTR_WINDOW_EN adds an interrupt window
// between REP iterations (intr_pending in, done_partial out).
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; registers latched on start
//   CHECK  | REP count test (and interrupt window when enabled)
//   RD_SRC | read [ESI] into mem_out_latched
//   RD_DST | read [EDI] into mem_out
//   CMP    | take ALU flags, commit ESI/EDI(/ECX), decide termination
//   FIN    | done pulse, back to IDLE
module cmps_seq
  import cmps_seq_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 flush,
  input  logic [1:0]           rep_mode,
  input  logic [1:0]           op_size,
  input  logic                 df,
  input  logic [AW-1:0]        esi_in,
  input  logic [AW-1:0]        edi_in,
  input  logic [AW-1:0]        ecx_in,
  output logic                 mem_rd_req,
  output logic [AW-1:0]        mem_rd_addr,
  output logic [1:0]           mem_rd_size,
  input  logic                 mem_rd_ready,
  input  logic [DW-1:0]        mem_rd_data,
  output logic [DW-1:0]        mem_out_latched,
  output logic [DW-1:0]        mem_out,
  input  logic [NUM_FLAGS-1:0] cmps_flags,
`ifdef CMPS_SEQ_INTR_WINDOW_EN
  input  logic                 intr_pending,
  output logic                 done_partial,
`endif
  output logic [AW-1:0]        esi_out,
  output logic [AW-1:0]        edi_out,
  output logic [AW-1:0]        ecx_out,
  output logic                 ld_esi,
  output logic                 ld_edi,
  output logic                 ld_ecx,
  output logic                 ld_flags,
  output logic [NUM_FLAGS-1:0] flags_out,
  output logic                 busy,
  output logic                 done
);

  state_t state, state_nxt;

  // operation context latched at start
  logic [1:0]    rep_q;
  logic [1:0]    size_q;
  logic          df_q;
  // working pointers used for addressing the next iteration
  logic [AW-1:0] esi_q, edi_q, ecx_q;
  // architectural values last committed in CMP
  logic [AW-1:0] esi_hold, edi_hold, ecx_hold;

  logic [AW-1:0] delta;
  logic [AW-1:0] esi_nxt, edi_nxt, ecx_nxt;
  logic          rep_active;
  logic          cnt_zero;
  logic          start_take;
  logic          cmp_commit;
  logic          zf;
  logic          terminate;

`ifdef CMPS_SEQ_INTR_WINDOW_EN
  logic first_q;
  logic partial_q;
  logic take_intr;
`endif

  cmps_ptr_step #(.AW(AW)) u_step (
    .op_size (size_q),
    .df      (df_q),
    .delta   (delta)
  );

  assign esi_nxt    = esi_q + delta;
  assign edi_nxt    = edi_q + delta;
  assign ecx_nxt    = ecx_q - AW'(1);
  assign rep_active = is_rep(rep_q);
  assign cnt_zero   = (ecx_q == '0);
  assign start_take = (state == IDLE) && start && !flush;
  // a flush in CMP drops the whole iteration: no loads, no pointer update
  assign cmp_commit = (state == CMP) && !flush;
  assign zf         = cmps_flags[FLAG_ZF];

  // REP ends on exhausted count or on the ZF condition of the prefix
  always_comb begin
    terminate = 1'b0;
    if (!rep_active) begin
      terminate = 1'b1;
    end else if (ecx_nxt == '0) begin
      terminate = 1'b1;
    end else if ((rep_q == REPE) && !zf) begin
      terminate = 1'b1;
    end else if ((rep_q == REPNE) && zf) begin
      terminate = 1'b1;
    end
  end

`ifdef CMPS_SEQ_INTR_WINDOW_EN
  // interrupts are only taken between iterations, never before the first
  assign take_intr = (state == CHECK) && !(rep_active && cnt_zero)
                     && intr_pending && !first_q;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = CHECK;
      end
      CHECK: begin
        if (rep_active && cnt_zero) begin
          state_nxt = FIN;
`ifdef CMPS_SEQ_INTR_WINDOW_EN
        end else if (take_intr) begin
          state_nxt = FIN;
`endif
        end else begin
          state_nxt = RD_SRC;
        end
      end
      RD_SRC: begin
        if (mem_rd_ready) state_nxt = RD_DST;
      end
      RD_DST: begin
        if (mem_rd_ready) state_nxt = CMP;
      end
      CMP: begin
        state_nxt = terminate ? FIN : CHECK;
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (flush) state_nxt = IDLE;
  end

  // operand capture, context latch and per-iteration commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q           <= REP_NONE;
      size_q          <= SZ_BYTE;
      df_q            <= 1'b0;
      esi_q           <= '0;
      edi_q           <= '0;
      ecx_q           <= '0;
      esi_hold        <= '0;
      edi_hold        <= '0;
      ecx_hold        <= '0;
      mem_out_latched <= '0;
      mem_out         <= '0;
      flags_out       <= '0;
    end else begin
      if (start_take) begin
        rep_q  <= rep_mode;
        size_q <= op_size;
        df_q   <= df;
        esi_q  <= esi_in;
        edi_q  <= edi_in;
        ecx_q  <= ecx_in;
      end
      if ((state == RD_SRC) && mem_rd_ready && !flush) begin
        mem_out_latched <= mem_rd_data;
      end
      if ((state == RD_DST) && mem_rd_ready && !flush) begin
        mem_out <= mem_rd_data;
      end
      if (cmp_commit) begin
        esi_q     <= esi_nxt;
        edi_q     <= edi_nxt;
        esi_hold  <= esi_nxt;
        edi_hold  <= edi_nxt;
        flags_out <= cmps_flags;
        if (rep_active) begin
          ecx_q    <= ecx_nxt;
          ecx_hold <= ecx_nxt;
        end
      end
    end
  end

`ifdef CMPS_SEQ_INTR_WINDOW_EN
  // tracks the first iteration and whether we left early for an interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q   <= 1'b0;
      partial_q <= 1'b0;
    end else begin
      if (start_take) begin
        first_q   <= 1'b1;
        partial_q <= 1'b0;
      end else begin
        if (cmp_commit) first_q <= 1'b0;
        if (take_intr && !flush) partial_q <= 1'b1;
      end
    end
  end

  assign done_partial = (state == FIN) && !flush && partial_q;
`endif

  // outputs; the new pointer values are shown combinationally in CMP so
  // they line up with their ld_* pulses
  always_comb begin
    mem_rd_req  = !flush && ((state == RD_SRC) || (state == RD_DST));
    mem_rd_addr = '0;
    if (state == RD_SRC) mem_rd_addr = esi_q;
    if (state == RD_DST) mem_rd_addr = edi_q;
    mem_rd_size = size_q;
    ld_esi      = cmp_commit;
    ld_edi      = cmp_commit;
    ld_flags    = cmp_commit;
    ld_ecx      = cmp_commit && rep_active;
    esi_out     = cmp_commit ? esi_nxt : esi_hold;
    edi_out     = cmp_commit ? edi_nxt : edi_hold;
    ecx_out     = (cmp_commit && rep_active) ? ecx_nxt : ecx_hold;
    busy        = (state != IDLE);
    done        = (state == FIN) && !flush;
  end

endmodule

// File: tb/tb_cmps_seq.sv
// Self-checking bench for cmps_seq: table of directed vectors plus a
// hand-written flush sequence.
module tb_cmps_seq;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, flush, df;
  logic [1:0]    rep_mode, op_size;
  logic [AW-1:0] esi_in, edi_in, ecx_in;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic [1:0]    mem_rd_size;
  logic          mem_rd_ready = 1'b0;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] mem_out_latched, mem_out;
  logic [5:0]    cmps_flags;
  logic [AW-1:0] esi_out, edi_out, ecx_out;
  logic          ld_esi, ld_edi, ld_ecx, ld_flags;
  logic [5:0]    flags_out;
  logic          busy, done;
`ifdef CMPS_SEQ_INTR_WINDOW_EN
  logic          intr_pending = 1'b0;
  logic          done_partial;
`endif

  cmps_seq #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .rep_mode(rep_mode), .op_size(op_size), .df(df),
    .esi_in(esi_in), .edi_in(edi_in), .ecx_in(ecx_in),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_size(mem_rd_size),
    .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data),
    .mem_out_latched(mem_out_latched), .mem_out(mem_out),
    .cmps_flags(cmps_flags),
`ifdef CMPS_SEQ_INTR_WINDOW_EN
    .intr_pending(intr_pending), .done_partial(done_partial),
`endif
    .esi_out(esi_out), .edi_out(edi_out), .ecx_out(ecx_out),
    .ld_esi(ld_esi), .ld_edi(ld_edi), .ld_ecx(ld_ecx), .ld_flags(ld_flags),
    .flags_out(flags_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // stand-in ALU: ZF on equality, CF on unsigned borrow
  assign cmps_flags = {1'b0, 1'b0, (mem_out_latched == mem_out), 1'b0, 1'b0,
                       (mem_out_latched < mem_out)};

  localparam logic [31:0] MEM_DEFAULT = 32'h5A5A_5A5A;
  localparam logic [31:0] LATE_DATA   = 32'hCAFE_F00D;

  logic [31:0] mem [logic [31:0]];
  int  tests = 0, fails = 0;
  int  wait_n = 0, wcnt = 0;
  bit  late_ready = 1'b0;
  logic prev_req = 1'b0, prev_ready = 1'b0;
  logic [31:0] prev_addr = '0;
  int  addr_err = 0, done_cnt = 0, ldf_cnt = 0, ldecx_cnt = 0, req_cnt = 0, ldany_cnt = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return MEM_DEFAULT;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // monitor + memory responder, both evaluated away from the rising edge
  always @(negedge clk) begin
    if (done)      done_cnt++;
    if (ld_flags)  ldf_cnt++;
    if (ld_ecx)    ldecx_cnt++;
    if (mem_rd_req) req_cnt++;
    if (ld_esi | ld_edi | ld_ecx | ld_flags) ldany_cnt++;
    if (mem_rd_req && prev_req && !prev_ready && (mem_rd_addr !== prev_addr)) addr_err++;
    prev_req  = mem_rd_req;
    prev_addr = mem_rd_addr;
    mem_rd_ready = 1'b0;
    if (late_ready) begin
      mem_rd_ready = 1'b1;
      mem_rd_data  = LATE_DATA;
    end else if (mem_rd_req) begin
      if (wcnt >= wait_n) begin
        mem_rd_ready = 1'b1;
        mem_rd_data  = mem_fn(mem_rd_addr);
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
    prev_ready = mem_rd_ready;
  end

  typedef struct {
    string       name;
    logic [1:0]  rep;
    logic [1:0]  sz;
    logic        df;
    logic [31:0] esi, edi, ecx;
    int          wait_n;
    logic [7:0]  mism;      // element k mismatches when bit k set
    logic [31:0] x_esi, x_edi, x_ecx;
    logic        x_zf;
    int          x_lat;
    int          x_iters;
    int          x_ldecx;
    bit          chk_ptr;
    bit          chk_ecx;
  } vec_t;

  vec_t v[9];

  task automatic run_vec(input vec_t t);
    int n;
    int step;
    logic [31:0] a;
    mem.delete();
    step = (t.sz == 2'd0) ? 1 : (t.sz == 2'd1) ? 2 : 4;
    for (int k = 0; k < 8; k++) begin
      if (t.mism[k]) begin
        a = t.df ? (t.esi - 32'(k * step)) : (t.esi + 32'(k * step));
        mem[a] = 32'h1234_0000 | 32'(k);
      end
    end
    wait_n = t.wait_n;
    @(negedge clk);
    rep_mode = t.rep; op_size = t.sz; df = t.df;
    esi_in = t.esi; edi_in = t.edi; ecx_in = t.ecx;
    start = 1'b1;
    done_cnt = 0; ldf_cnt = 0; ldecx_cnt = 0; req_cnt = 0; ldany_cnt = 0; addr_err = 0;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    chk({t.name, " busy"}, busy, 1);
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({t.name, " latency"}, n, t.x_lat);
    @(negedge clk);
    @(negedge clk);
    chk({t.name, " done_count"}, done_cnt, 1);
    chk({t.name, " iterations"}, ldf_cnt, t.x_iters);
    chk({t.name, " ld_ecx_count"}, ldecx_cnt, t.x_ldecx);
    chk({t.name, " addr_stable"}, addr_err, 0);
    chk({t.name, " rd_size"}, mem_rd_size, t.sz);
    if (t.x_iters == 0) begin
      chk({t.name, " no_req"}, req_cnt, 0);
      chk({t.name, " no_ld"}, ldany_cnt, 0);
    end
    if (t.chk_ptr) begin
      chk({t.name, " esi_out"}, esi_out, t.x_esi);
      chk({t.name, " edi_out"}, edi_out, t.x_edi);
      chk({t.name, " flags_out"}, flags_out, {26'd0, 2'b00, t.x_zf, 2'b00, ~t.x_zf});
    end
    if (t.chk_ecx) chk({t.name, " ecx_out"}, ecx_out, t.x_ecx);
  endtask

  initial begin
    vec_t again;
    //      name            rep    sz     df  esi           edi           ecx   wt mism   x_esi         x_edi         x_ecx zf lat it ldc ptr ecx
    v[0] = '{"nonrep_byte",  2'b00, 2'd0, 0, 32'h100,      32'h200,      32'd7, 0, 8'h00, 32'h101,      32'h201,      32'd0, 1, 5,  1, 0, 1, 1};
    v[1] = '{"repe_dw_dn",   2'b01, 2'd2, 1, 32'h1000,     32'h2000,     32'd3, 0, 8'h02, 32'hFF8,      32'h1FF8,     32'd1, 0, 9,  2, 2, 1, 1};
    v[2] = '{"repne_w_cnt",  2'b10, 2'd1, 0, 32'h300,      32'h400,      32'd1, 0, 8'h01, 32'h302,      32'h402,      32'd0, 0, 5,  1, 1, 1, 1};
    v[3] = '{"rep_ecx0",     2'b01, 2'd0, 0, 32'h123,      32'h456,      32'd0, 0, 8'h00, 32'h302,      32'h402,      32'd0, 0, 2,  0, 0, 1, 1};
    v[4] = '{"wait3_dw",     2'b00, 2'd2, 0, 32'h40,       32'h80,       32'd0, 3, 8'h00, 32'h44,       32'h84,       32'd0, 1, 11, 1, 0, 1, 1};
    v[5] = '{"esi_wrap",     2'b00, 2'd0, 0, 32'hFFFFFFFF, 32'h10,       32'd0, 0, 8'h00, 32'h0,        32'h11,       32'd0, 1, 5,  1, 0, 1, 1};
    v[6] = '{"repne_b_hit",  2'b10, 2'd0, 1, 32'h500,      32'h600,      32'd5, 0, 8'h03, 32'h4FD,      32'h5FD,      32'd2, 1, 13, 3, 3, 1, 1};
    v[7] = '{"repe_w_run",   2'b01, 2'd1, 0, 32'h700,      32'h800,      32'd2, 0, 8'h00, 32'h704,      32'h804,      32'd0, 1, 9,  2, 2, 1, 1};
    v[8] = '{"rep11_sz3",    2'b11, 2'd3, 0, 32'h900,      32'hA00,      32'd9, 0, 8'h00, 32'h904,      32'hA04,      32'd0, 1, 5,  1, 0, 1, 1};

    rst = 1'b1; start = 1'b0; flush = 1'b0; rep_mode = 2'b00; op_size = 2'd0; df = 1'b0;
    esi_in = '0; edi_in = '0; ecx_in = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst req", mem_rd_req, 0);
    chk("rst esi_out", esi_out, 0);
    chk("rst ecx_out", ecx_out, 0);
    chk("rst mem_out_latched", mem_out_latched, 0);
    chk("rst flags_out", flags_out, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle busy", busy, 0);

    for (int i = 0; i < 9; i++) run_vec(v[i]);

    // flush during RD_DST of the 2nd REPE iteration, with a stray start
    mem.delete();
    wait_n = 0;
    @(negedge clk);
    rep_mode = 2'b01; op_size = 2'd0; df = 1'b0;
    esi_in = 32'hA00; edi_in = 32'hB00; ecx_in = 32'd4;
    start = 1'b1;
    done_cnt = 0; ldf_cnt = 0; ldecx_cnt = 0; req_cnt = 0; ldany_cnt = 0;
    @(negedge clk);                     // n=1 CHECK
    start = 1'b0;
    @(negedge clk);                     // n=2 RD_SRC
    start = 1'b1; esi_in = 32'hF00;
    @(negedge clk);                     // n=3 RD_DST
    start = 1'b0;
    repeat (4) @(negedge clk);          // n=7 RD_DST of iteration 2
    chk("flush pre addr", mem_rd_addr, 32'hB01);
    chk("flush pre req", mem_rd_req, 1);
    flush = 1'b1;
    @(negedge clk);                     // n=8
    flush = 1'b0;
    chk("flush busy", busy, 0);
    chk("flush esi_out", esi_out, 32'hA01);
    chk("flush edi_out", edi_out, 32'hB01);
    chk("flush ecx_out", ecx_out, 32'd3);
    chk("flush ld_flags_count", ldf_cnt, 1);
    late_ready = 1'b1;
    repeat (2) @(negedge clk);
    late_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("flush late mem_out", mem_out, MEM_DEFAULT);
    chk("flush late mem_out_latched", mem_out_latched, MEM_DEFAULT);
    chk("flush still idle", busy, 0);
    chk("flush no done", done_cnt, 0);

    again = v[0];
    again.name = "post_flush";
    again.chk_ecx = 0;
    run_vec(again);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
